// File: rtl/pipeline_stage_skid.sv
// Pipeline register with a DEPTH-entry skid FIFO behind it. Early back-pressure is driven
// from FIFO occupancy, and a word dropped while the FIFO is full raises a one-cycle overflow pulse.
module pipeline_stage_skid #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STALL_THRESH = 1,
    parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_flush,
    input  logic [WIDTH-1:0] inputs,
    input  logic             in_valid,
    input  logic             in_stall,
    output logic [WIDTH-1:0] outputs,
    output logic             out_valid,
    output logic             out_flush,
    output logic             out_stall,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_CNT = CNT_W'(STALL_THRESH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             flush_q;
    logic             overflow_q;

    logic load_ok, empty, full;
    logic deq, bypass, enq, drop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == FULL_CNT);
        load_ok = !valid_q || !in_stall;
        deq     = load_ok && !empty;
        // The FIFO head always takes priority, so the live input may bypass only when it is empty.
        bypass  = load_ok && empty && in_valid;
        enq     = in_valid && !bypass && (!full || deq);
        drop    = in_valid && !bypass && full && !deq;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (enq) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (enq && !deq) begin
            count_d = count_q + CNT_W'(1);
        end else if (deq && !enq) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage is not reset; entries are only read when count marks them as written.
    always_ff @(posedge clk) begin
        if (enq && !in_flush) begin
            mem_q[wr_ptr_q] <= inputs;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (in_flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            flush_q <= in_flush;
            if (in_flush) begin
                data_q     <= '0;
                valid_q    <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                overflow_q <= drop;
                if (deq) begin
                    data_q  <= mem_q[rd_ptr_q];
                    valid_q <= 1'b1;
                end else if (bypass) begin
                    data_q  <= inputs;
                    valid_q <= 1'b1;
                end else if (load_ok) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        outputs   = data_q;
        out_valid = valid_q;
        out_flush = flush_q;
        overflow  = overflow_q;
        count     = count_q;
        // Depends on registered occupancy only, so no input-to-out_stall path exists.
        out_stall = (count_q >= THRESH_CNT);
    end

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Directed bench for pipeline_stage_skid (WIDTH=32, DEPTH=4, STALL_THRESH=2).
module tb_pipeline_stage_skid;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_flush;
    logic [31:0] inputs;
    logic        in_valid;
    logic        in_stall;
    logic [31:0] outputs;
    logic        out_valid;
    logic        out_flush;
    logic        out_stall;
    logic [2:0]  count;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_stage_skid #(
        .WIDTH(32),
        .DEPTH(4),
        .STALL_THRESH(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_flush(in_flush),
        .inputs(inputs),
        .in_valid(in_valid),
        .in_stall(in_stall),
        .outputs(outputs),
        .out_valid(out_valid),
        .out_flush(out_flush),
        .out_stall(out_stall),
        .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks data only when a valid word is expected.
    task automatic expect_state(input string tag, input logic v, input logic [31:0] d,
                                input int c, input logic s);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (v) check({tag, ".data"}, outputs, d);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".stall"}, 32'(out_stall), 32'(s));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic st);
        in_valid = v;
        inputs   = d;
        in_stall = st;
    endtask

    initial begin
        reset_n  = 1'b0;
        in_flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        tick();
        tick();
        check("rst.outputs", outputs, 32'h0);
        check("rst.flush", 32'(out_flush), 32'h0);
        check("rst.ovf", 32'(overflow), 32'h0);
        expect_state("rst", 1'b0, 32'h0, 0, 1'b0);
        reset_n = 1'b1;

        // Streaming through the bypass path
        drive(1'b1, 32'h11, 1'b0); tick(); expect_state("str0", 1'b1, 32'h11, 0, 1'b0);
        drive(1'b1, 32'h22, 1'b0); tick(); expect_state("str1", 1'b1, 32'h22, 0, 1'b0);
        drive(1'b1, 32'h33, 1'b0); tick(); expect_state("str2", 1'b1, 32'h33, 0, 1'b0);
        drive(1'b0, 32'h0, 1'b0);  tick(); expect_state("str3", 1'b0, 32'h0, 0, 1'b0);

        // Stall fill
        drive(1'b1, 32'hA0, 1'b0); tick(); expect_state("fill0", 1'b1, 32'hA0, 0, 1'b0);
        drive(1'b1, 32'hA1, 1'b1); tick(); expect_state("fill1", 1'b1, 32'hA0, 1, 1'b0);
        drive(1'b1, 32'hA2, 1'b1); tick(); expect_state("fill2", 1'b1, 32'hA0, 2, 1'b1);
        drive(1'b1, 32'hA3, 1'b1); tick(); expect_state("fill3", 1'b1, 32'hA0, 3, 1'b1);
        drive(1'b1, 32'hA4, 1'b1); tick(); expect_state("fill4", 1'b1, 32'hA0, 4, 1'b1);
        check("fill4.ovf", 32'(overflow), 32'h0);

        // Overflow while full and stalled
        drive(1'b1, 32'hDEAD, 1'b1); tick(); expect_state("ovf0", 1'b1, 32'hA0, 4, 1'b1);
        check("ovf0.pulse", 32'(overflow), 32'h1);
        drive(1'b0, 32'h0, 1'b1); tick(); expect_state("ovf1", 1'b1, 32'hA0, 4, 1'b1);
        check("ovf1.pulse", 32'(overflow), 32'h0);

        // Full with simultaneous enqueue and dequeue, then drain
        drive(1'b1, 32'hBEEF, 1'b0); tick(); expect_state("sim", 1'b1, 32'hA1, 4, 1'b1);
        check("sim.ovf", 32'(overflow), 32'h0);
        drive(1'b0, 32'h0, 1'b0);
        tick(); expect_state("drn0", 1'b1, 32'hA2, 3, 1'b1);
        tick(); expect_state("drn1", 1'b1, 32'hA3, 2, 1'b1);
        tick(); expect_state("drn2", 1'b1, 32'hA4, 1, 1'b0);
        tick(); expect_state("drn3", 1'b1, 32'hBEEF, 0, 1'b0);
        tick(); expect_state("drn4", 1'b0, 32'h0, 0, 1'b0);

        // Flush with three words buffered
        drive(1'b1, 32'hB0, 1'b0); tick();
        drive(1'b1, 32'hB1, 1'b1); tick();
        drive(1'b1, 32'hB2, 1'b1); tick();
        drive(1'b1, 32'hB3, 1'b1); tick(); expect_state("fpre", 1'b1, 32'hB0, 3, 1'b1);
        in_flush = 1'b1;
        drive(1'b1, 32'hCC, 1'b0); tick();
        expect_state("fl0", 1'b0, 32'h0, 0, 1'b0);
        check("fl0.outputs", outputs, 32'h0);
        check("fl0.oflush", 32'(out_flush), 32'h1);
        in_flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0); tick();
        expect_state("fl1", 1'b0, 32'h0, 0, 1'b0);
        check("fl1.oflush", 32'(out_flush), 32'h0);

        // Flush held for two cycles
        in_flush = 1'b1; tick(); tick();
        check("fh1.oflush", 32'(out_flush), 32'h1);
        in_flush = 1'b0; tick();
        check("fh2.oflush", 32'(out_flush), 32'h0);

        // Asynchronous reset between edges with two words buffered
        drive(1'b1, 32'hC0, 1'b0); tick();
        drive(1'b1, 32'hC1, 1'b1); tick();
        drive(1'b1, 32'hC2, 1'b1); tick(); expect_state("rpre", 1'b1, 32'hC0, 2, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        expect_state("arst", 1'b0, 32'h0, 0, 1'b0);
        check("arst.outputs", outputs, 32'h0);
        tick();
        #2 reset_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        tick();
        expect_state("post", 1'b0, 32'h0, 0, 1'b0);
        check("post.outputs", outputs, 32'h0);
        drive(1'b1, 32'hD0, 1'b0); tick(); expect_state("post1", 1'b1, 32'hD0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
